// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared definitions for the bit-serial adder: the controller state
//   encoding and the legal operand width range with its check function.
//   No ports; imported by serial_adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MIN_WIDTH = 1;
  localparam int MAX_WIDTH = 64;

  function automatic bit width_is_legal(input int w);
    return (w >= MIN_WIDTH) && (w <= MAX_WIDTH);
  endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// full_adder
//   Purely combinational one-bit full adder; the single arithmetic cell
//   of the bit-serial adder.
// Ports:
//   a, b   in   addend bits
//   cin    in   carry in
//   sum    out  a ^ b ^ cin
//   carry  out  majority(a, b, cin)
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial WIDTH-bit adder. An accepted start captures a, b and cin;
//   the sum is then formed one bit per clock, LSB first, through a single
//   full_adder and a carry flop. {cout,sum} = a + b + cin.
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   begin an addition (accepted in IDLE or DONE)
//   a, b   in   WIDTH-bit operands, captured on accepted start
//   cin    in   carry in, captured on accepted start
//   busy   out  high while in RUN
//   done   out  one-cycle pulse; sum/cout valid in that cycle
//   sum    out  WIDTH-bit result, held until the next completion
//   cout   out  carry-out, held until the next completion
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  generate
    if (!width_is_legal(WIDTH)) begin : g_bad_width
      $error("serial_adder: WIDTH must lie in 1..64");
    end
  endgenerate

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] op_a_reg, op_b_reg, acc_reg, sum_reg;
  logic [WIDTH-1:0] acc_shifted;
  logic [CNT_W-1:0] count_reg;
  logic             carry_reg, cout_reg;
  logic             fa_sum, fa_carry;
  logic             accept, last_bit;

  full_adder u_full_adder (
    .a     (op_a_reg[0]),
    .b     (op_b_reg[0]),
    .cin   (carry_reg),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // A start is taken in IDLE and in DONE (back-to-back), never in RUN.
  assign accept   = start && (state_reg != RUN);
  assign last_bit = (count_reg == LAST_BIT);

  // Accumulator after this cycle's shift: new sum bit enters at the MSB,
  // so after WIDTH shifts bit 0 of the result has reached position 0.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_acc_shift
      assign acc_shifted[gi] = acc_reg[gi+1];
    end
  endgenerate
  assign acc_shifted[WIDTH-1] = fa_sum;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from the state register only
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_reg)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand/accumulator shifters, carry flop, bit counter and
  // the result registers, which update only on the final compute edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_reg  <= '0;
      op_b_reg  <= '0;
      acc_reg   <= '0;
      carry_reg <= 1'b0;
      count_reg <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
    end else if (accept) begin
      op_a_reg  <= a;
      op_b_reg  <= b;
      acc_reg   <= '0;
      carry_reg <= cin;
      count_reg <= '0;
    end else if (state_reg == RUN) begin
      op_a_reg  <= op_a_reg >> 1;
      op_b_reg  <= op_b_reg >> 1;
      acc_reg   <= acc_shifted;
      carry_reg <= fa_carry;
      count_reg <= count_reg + CNT_W'(1);
      if (last_bit) begin
        sum_reg  <= acc_shifted;
        cout_reg <= fa_carry;
      end
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder
//   Directed and randomized checks of serial_adder at WIDTH = 8, 1 and 64
//   against a plain-arithmetic model {cout,sum} = a + b + cin.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  // WIDTH = 8 instance
  logic        start8 = 1'b0, cin8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, cout8;
  logic [7:0]  sum8;
  // WIDTH = 1 instance
  logic        start1 = 1'b0, cin1 = 1'b0;
  logic [0:0]  a1 = '0, b1 = '0;
  logic        busy1, done1, cout1;
  logic [0:0]  sum1;
  // WIDTH = 64 instance
  logic        start64 = 1'b0, cin64 = 1'b0;
  logic [63:0] a64 = '0, b64 = '0;
  logic        busy64, done64, cout64;
  logic [63:0] sum64;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );
  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );
  serial_adder #(.WIDTH(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .start(start64), .a(a64), .b(b64), .cin(cin64),
    .busy(busy64), .done(done64), .sum(sum64), .cout(cout64)
  );

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic busy_of(input int w);
    return (w == 1) ? busy1 : (w == 8) ? busy8 : busy64;
  endfunction
  function automatic logic done_of(input int w);
    return (w == 1) ? done1 : (w == 8) ? done8 : done64;
  endfunction
  function automatic logic cout_of(input int w);
    return (w == 1) ? cout1 : (w == 8) ? cout8 : cout64;
  endfunction
  function automatic logic [63:0] sum_of(input int w);
    return (w == 1) ? {63'b0, sum1} : (w == 8) ? {56'b0, sum8} : sum64;
  endfunction

  task automatic drive(input int w, input logic s, input logic [63:0] av,
                       input logic [63:0] bv, input logic ci);
    case (w)
      1:       begin start1 = s;  a1 = av[0:0];  b1 = bv[0:0];  cin1 = ci;  end
      8:       begin start8 = s;  a8 = av[7:0];  b8 = bv[7:0];  cin8 = ci;  end
      default: begin start64 = s; a64 = av;      b64 = bv;      cin64 = ci; end
    endcase
  endtask

  // One complete addition with the model's expected result; operands are
  // scrambled right after acceptance to show they are not re-sampled.
  task automatic op(input int w, input logic [63:0] av, input logic [63:0] bv,
                    input logic ci, input string tag);
    logic [63:0] mask;
    logic [64:0] ref_v;
    int nb, guard;
    mask  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    ref_v = {1'b0, av & mask} + {1'b0, bv & mask} + {64'b0, ci};
    @(negedge clk);
    drive(w, 1'b1, av, bv, ci);
    @(negedge clk);
    drive(w, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
    nb = 0;
    guard = 0;
    while (busy_of(w) && guard < 200) begin
      nb++;
      guard++;
      @(negedge clk);
    end
    check({tag, " busy_cycles"}, 65'(nb), 65'(w));
    check({tag, " done"}, {64'b0, done_of(w)}, 65'd1);
    check({tag, " sum"}, {1'b0, sum_of(w)}, {1'b0, ref_v[63:0] & mask});
    check({tag, " cout"}, {64'b0, cout_of(w)}, {64'b0, ref_v[w]});
    $display("w=%0d %s a=%h b=%h cin=%0d -> sum=%h cout=%0d", w, tag,
             av & mask, bv & mask, ci, sum_of(w), cout_of(w));
    @(negedge clk);
    check({tag, " done_one_cycle"}, {64'b0, done_of(w)}, 65'd0);
  endtask

  initial begin : main
    int ndone, first_cyc, guard;
    logic [7:0] pa [3];
    logic [7:0] pb [3];
    logic [8:0] exp9;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("rst busy8", {64'b0, busy8}, 65'd0);
    check("rst done8", {64'b0, done8}, 65'd0);
    check("rst sum8", {57'b0, sum8}, 65'd0);
    check("rst cout8", {64'b0, cout8}, 65'd0);
    check("rst sum64", {1'b0, sum64}, 65'd0);
    check("rst busy1", {64'b0, busy1}, 65'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // ---- directed WIDTH=8 ----
    op(8, 64'h5A, 64'h3C, 1'b0, "w8_5a_3c");
    op(8, 64'hFF, 64'h01, 1'b0, "w8_ff_01");
    op(8, 64'hFF, 64'hFF, 1'b1, "w8_ff_ff_c");

    // ---- start during RUN is ignored ----
    @(negedge clk);
    drive(8, 1'b1, 64'h10, 64'h20, 1'b0);
    @(negedge clk);                          // after E0
    drive(8, 1'b0, 64'hFF, 64'hFF, 1'b0);
    @(negedge clk);                          // after E1
    @(negedge clk);                          // after E2
    start8 = 1'b1;                           // sampled at E3
    @(negedge clk);
    start8 = 1'b0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      if (done8) begin
        ndone++;
        if (ndone == 1) begin
          check("ign sum", {57'b0, sum8}, 65'h30);
          check("ign cout", {64'b0, cout8}, 65'd0);
        end
      end
      @(negedge clk);
    end
    check("ign done_count", 65'(ndone), 65'd1);
    $display("w=8 ignore_start a=10 b=20 -> sum=%h cout=%0d dones=%0d", sum8, cout8, ndone);

    // ---- asynchronous reset mid-RUN ----
    op(8, 64'hF0, 64'h20, 1'b0, "w8_f0_20");  // leaves sum=10, cout=1
    @(negedge clk);
    drive(8, 1'b1, 64'h33, 64'h44, 1'b0);
    @(negedge clk);                          // after E0
    start8 = 1'b0;
    repeat (3) @(negedge clk);               // after E3
    @(posedge clk);                          // E4
    #1 rst_n = 1'b0;
    #1;
    check("arst busy", {64'b0, busy8}, 65'd0);
    check("arst done", {64'b0, done8}, 65'd0);
    check("arst sum", {57'b0, sum8}, 65'd0);
    check("arst cout", {64'b0, cout8}, 65'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done8 || busy8) ndone++;
    end
    check("arst no_done", 65'(ndone), 65'd0);
    $display("w=8 reset_mid_run -> busy/done activity after reset=%0d", ndone);
    op(8, 64'h01, 64'h01, 1'b0, "w8_after_rst");

    // ---- start held high: back-to-back ----
    pa[0] = 8'h01; pb[0] = 8'h02;
    pa[1] = 8'h03; pb[1] = 8'h04;
    pa[2] = 8'h80; pb[2] = 8'h80;
    @(negedge clk);
    drive(8, 1'b1, {56'b0, pa[0]}, {56'b0, pb[0]}, 1'b0);
    @(negedge clk);                          // pair 0 accepted
    drive(8, 1'b1, {56'b0, pa[1]}, {56'b0, pb[1]}, 1'b0);
    first_cyc = 0;
    for (int k = 0; k < 3; k++) begin
      guard = 0;
      while (!done8 && guard < 50) begin
        guard++;
        @(negedge clk);
      end
      exp9 = {1'b0, pa[k]} + {1'b0, pb[k]};
      check($sformatf("b2b%0d done", k), {64'b0, done8}, 65'd1);
      check($sformatf("b2b%0d sum", k), {57'b0, sum8}, {57'b0, exp9[7:0]});
      check($sformatf("b2b%0d cout", k), {64'b0, cout8}, {64'b0, exp9[8]});
      if (k > 0) check($sformatf("b2b%0d period", k), 65'(cyc - first_cyc), 65'(9 * k));
      else first_cyc = cyc;
      $display("w=8 b2b%0d a=%h b=%h -> sum=%h cout=%0d cycle=%0d", k, pa[k], pb[k], sum8, cout8, cyc);
      if (k == 2) start8 = 1'b0;
      @(negedge clk);                        // next pair accepted at that edge
      if (k == 0) drive(8, 1'b1, {56'b0, pa[2]}, {56'b0, pb[2]}, 1'b0);
    end
    repeat (2) @(negedge clk);

    // ---- random WIDTH=8 ----
    for (int i = 0; i < 6; i++)
      op(8, {56'b0, 8'($urandom)}, {56'b0, 8'($urandom)}, 1'($urandom), $sformatf("w8_rnd%0d", i));

    // ---- WIDTH=1 exhaustive ----
    for (int i = 0; i < 8; i++)
      op(1, {63'b0, i[2]}, {63'b0, i[1]}, i[0], $sformatf("w1_%0d", i));

    // ---- WIDTH=64 ----
    op(64, '1, 64'd0, 1'b1, "w64_carry_chain");
    op(64, '1, '1, 1'b1, "w64_all_ones");
    for (int i = 0; i < 10; i++)
      op(64, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), $sformatf("w64_rnd%0d", i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial, parametrised-width adder: captures two WIDTH-bit operands and a carry-in on a start request, then adds one bit per clock, LSB first, through a single full-adder cell and a carry flop. It is the sequential, multi-bit successor to the team's combinational half adder. It targets area-constrained datapaths where WIDTH cycles of latency is acceptable. It uses a start/busy/done handshake for use by a simple controller or testbench driver.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range 1..64
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset; release is synchronised externally
- start  input  1  request to begin an addition; sampled on the rising edge of clk
- a  input  WIDTH  operand A; captured only on an accepted start
- b  input  WIDTH  operand B; captured only on an accepted start
- cin  input  1  carry-in; captured only on an accepted start
- busy  output  1  high while an addition is in progress (state RUN)
- done  output  1  one-cycle pulse; sum/cout are valid in the same cycle
- sum  output  WIDTH  result of the last completed addition, held until the next completion
- cout  output  1  carry-out of the last completed addition, held until the next completion

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 → load opA←a, opB←b, carry←cin, acc←0, bit count←0.
  - Go to RUN.
- RUN, on each edge:
  - s = opA[0]^opB[0]^carry; carry ← majority(opA[0], opB[0], carry).
  - opA and opB shift right by 1.
  - acc shifts right with s entering at bit WIDTH-1.
  - count increments.
  - On the edge that processes bit WIDTH-1 (count==WIDTH-1): sum←final acc value, cout←final carry, go to DONE.
- DONE: done=1 for exactly one cycle.
  - start=1 in DONE is accepted: operands are loaded as in IDLE and the state goes to RUN (back-to-back operation).
  - Otherwise go to IDLE.
- start while in RUN is ignored; no queuing.
- Changes on a, b and cin after acceptance have no effect on the running addition.
- Arithmetic: {cout,sum} = a + b + cin, exact, WIDTH+1 bits; no saturation.
- Bit counter width is $clog2(WIDTH+1).
- WIDTH=1: RUN lasts exactly one cycle.
- Reset (asynchronous, any state, including mid-RUN):
  - state←IDLE, busy=0, done=0, sum=0, cout=0.
  - carry, count, opA, opB and acc ← 0.
  - The aborted addition produces no done.

## Timing
- Start accepted at edge E0.
- busy is high from E0 through edge E(WIDTH), i.e. for WIDTH cycles.
- done is high for the single cycle after edge E(WIDTH).
- Latency, start sample to done: WIDTH+1 edges (E0 load, then WIDTH compute edges).
- Back-to-back throughput: one result per WIDTH+1 cycles.
- sum and cout change only on the edge entering DONE; they are registered, with no combinational path from inputs.
- busy and done are decoded from the state register and are glitch-free registered-state outputs.

## Structure
- Package serial_adder_pkg holds the state enum (IDLE, RUN, DONE) and the WIDTH legality check.
- Sub-module full_adder (a, b, cin → sum, carry), purely combinational, instantiated once.
  - It is a reusable sibling of half_adder and gets its own exhaustive 8-vector bench.
- Top level contains the FSM, the operand and accumulator shift registers, the carry flop and the counter.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, cin=0 → done in the cycle after E8; sum=0x96, cout=0; busy high for exactly 8 cycles.
- WIDTH=8, a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
- start pulsed at E3 of a running 0x10+0x20 with a=b=0xFF on the bus → ignored; result is 0x30, cout=0; exactly one done.
- rst_n driven low mid-RUN at E4 → busy, done, sum and cout go to 0 immediately (asynchronously); no done follows. A fresh start 0x01+0x01 → sum=0x02.
- start held high continuously with operand pairs (1,2), (3,4), (0x80,0x80) → done every 9 cycles; results 0x03/0, 0x07/0, 0x00/1.
- WIDTH=1, all 8 combinations of a, b, cin → {cout,sum} equals a+b+cin; done 2 edges after start. WIDTH=64 random sweep is checked against a reference model.
